sw_debounce: RTL
================

// Module: sw_debounce
// PURPOSE
//   Front end for the board switch inputs. Raw, asynchronous, bouncing switch
//   levels enter here; clean, synchronised levels leave for the downstream logic
//   stage (e.g. the a/b -> f XOR datapath).
//   Each channel has its own synchroniser, stability counter and edge detector.
//   Also emits one-cycle rise/fall pulses for future sequential consumers.
// PARAMETERS
//   N_SW         2   number of independent switch channels
//   SYNC_STAGES  2   flip-flop synchroniser depth per channel (>=2)
//   DB_CYCLES    16  consecutive cycles a new level must hold before acceptance (>=1)
//   CNT_W        $clog2(DB_CYCLES+1)  derived localparam, counter width; not overridable
// PORTS
//   clk       in   1      system clock; all state on posedge
//   rst_n     in   1      asynchronous, active-low reset
//   sw_raw    in   N_SW   raw switch levels, asynchronous to clk
//   sw_db     out  N_SW   debounced level, registered
//   sw_rise   out  N_SW   1-cycle pulse, coincident with sw_db going 0->1
//   sw_fall   out  N_SW   1-cycle pulse, coincident with sw_db going 1->0
//   busy      out  N_SW   channel currently qualifying a candidate level (state COUNT)
// BEHAVIOUR
//   Reset (rst_n low, async assert):
//     - synchroniser flops, sw_db, sw_rise, sw_fall, busy, counters all 0
//     - state STABLE
//   Reset release:
//     - first active edge is the first posedge with rst_n high
//     - a switch already at 1 then qualifies normally and produces sw_rise
//   Synchroniser: sync = sw_raw after SYNC_STAGES flops; only sync is used downstream.
//   Per-channel FSM (2 states):
//     STABLE: sync == sw_db -> stay, cnt = 0.
//       sync != sw_db -> COUNT, cnt <= 1; if DB_CYCLES == 1, accept immediately
//       (see accept rule below).
//     COUNT: sync == sw_db (bounce back) -> STABLE, cnt <= 0, no output change.
//       sync != sw_db and cnt == DB_CYCLES-1 -> accept.
//       Otherwise cnt <= cnt + 1.
//     Accept: sw_db <= sync, pulse asserted, cnt <= 0, -> STABLE.
//   Pulses: sw_rise/sw_fall are registered, high exactly the cycle sw_db shows the
//     new value, low otherwise. Never both high on one channel.
//   Latency: a clean step on sw_raw appears on sw_db after SYNC_STAGES + DB_CYCLES
//     posedges (step sampled at edge 1).
//   Glitch rejection: any excursion shorter than DB_CYCLES synced cycles is dropped.
//   Counter: saturating by construction, never exceeds DB_CYCLES-1, never wraps.
//   Channels are fully independent: simultaneous changes on several channels
//     qualify in parallel, and outputs may update on the same cycle.
//   Reset mid-count: counter and candidate are discarded; sw_db returns to 0.
//   busy == (state == COUNT).
// STRUCTURE
//   Package sw_debounce_pkg:
//     - state enum {ST_STABLE, ST_COUNT}
//     - default constants for SYNC_STAGES and DB_CYCLES
//   Sub-module sw_debounce_ch:
//     - one channel: synchroniser + FSM + counter + edge regs
//     - sw_debounce instantiates N_SW copies via generate loop; no glue logic beyond
//       bit slicing
// TESTING (SYNC_STAGES=2, DB_CYCLES=4, N_SW=2 unless noted)
//   1. rst_n=0, then 1 with sw_raw=00.
//      -> sw_db=00, pulses 0 throughout.
//      Assert rst_n async mid-cycle -> outputs 0 before next edge.
//   2. sw_raw[0] 0->1 held.
//      -> sw_db[0]=1 at posedge 6 after change; sw_rise[0]=1 that cycle only;
//         busy[0] high 3 cycles before.
//   3. sw_raw[0] high for 3 cycles, then back to 0.
//      -> sw_db stays 0; no pulses; busy[0] returns 0.
//   4. Bounce pattern 1,0,1,0,1 (1 cycle each), then steady 1.
//      -> single sw_rise, 4 stable cycles after the last bounce, plus sync delay.
//      Release to 0 -> single sw_fall.
//   5. sw_raw 00->11 on same cycle.
//      -> sw_db=11 on same edge; sw_rise=11 for one cycle.
//   6. rst_n pulsed low while busy[1]=1 during a qualifying 1 on channel 1.
//      -> sw_db[1]=0 and no sw_rise.
//      After release with input still 1 -> full requalification, rise at edge 6.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer.
// Contents:
//   state_t             per-channel qualification state
//   DEF_N_SW            default number of switch channels
//   DEF_SYNC_STAGES     default synchroniser depth
//   DEF_DB_CYCLES       default number of stable cycles needed to accept a level
package sw_debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  localparam int DEF_N_SW        = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 16;

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bundle between the board inputs, the debouncer and its consumers.
// Signals (all N_SW wide):
//   sw_raw   raw switch levels, asynchronous to clk
//   sw_db    debounced levels
//   sw_rise  one-cycle pulse on a debounced 0->1 change
//   sw_fall  one-cycle pulse on a debounced 1->0 change
//   busy     channel is qualifying a candidate level
// Modports: master drives sw_raw and observes the rest; slave is the debouncer.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int N_SW = DEF_N_SW
);

  logic [N_SW-1:0] sw_raw;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic [N_SW-1:0] busy;

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  busy
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output busy
  );

endinterface

// File: rtl/sw_debounce_ch.sv
// One debouncer channel: synchroniser, two-state qualification FSM with a
// stability counter, and registered edge pulses.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   sw_raw   in   raw switch level (asynchronous)
//   sw_db    out  debounced level, registered
//   sw_rise  out  pulse in the cycle sw_db becomes 1
//   sw_fall  out  pulse in the cycle sw_db becomes 0
//   busy     out  high while a candidate level is being qualified
module sw_debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               db_r;
  logic               db_nxt_s;
  logic               rise_r;
  logic               rise_nxt_s;
  logic               fall_r;
  logic               fall_nxt_s;
  logic               busy_r;

  // Synchroniser shift chain; only the last stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sw_raw};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Next-state, counter and pulse decisions for the qualification FSM.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    db_nxt_s    = db_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      ST_STABLE: begin
        if (sync_s != db_r) begin
          if (DB_CYCLES == 1) begin
            // A single matching cycle is enough: accept without visiting COUNT.
            db_nxt_s   = sync_s;
            rise_nxt_s = sync_s;
            fall_nxt_s = ~sync_s;
            cnt_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_COUNT;
            cnt_nxt_s   = CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = '0;
        end
      end
      ST_COUNT: begin
        if (sync_s == db_r) begin
          // Bounced back to the current level: drop the candidate.
          state_nxt_s = ST_STABLE;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_W'(DB_CYCLES - 1)) begin
          state_nxt_s = ST_STABLE;
          cnt_nxt_s   = '0;
          db_nxt_s    = sync_s;
          rise_nxt_s  = sync_s;
          fall_nxt_s  = ~sync_s;
        end else begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_STABLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_STABLE;
      cnt_r   <= '0;
      db_r    <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      db_r    <= db_nxt_s;
      rise_r  <= rise_nxt_s;
      fall_r  <= fall_nxt_s;
      busy_r  <= (state_nxt_s == ST_COUNT);
    end
  end

  assign sw_db   = db_r;
  assign sw_rise = rise_r;
  assign sw_fall = fall_r;
  assign busy    = busy_r;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: N_SW independent copies of sw_debounce_ch.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   bus     sw_debounce_if.slave: sw_raw in; sw_db, sw_rise, sw_fall, busy out
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N_SW        = DEF_N_SW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input logic          clk,
  input logic          rst_n,
  sw_debounce_if.slave bus
);

  logic [N_SW-1:0] db_s;
  logic [N_SW-1:0] rise_s;
  logic [N_SW-1:0] fall_s;
  logic [N_SW-1:0] busy_s;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (bus.sw_raw[i]),
      .sw_db   (db_s[i]),
      .sw_rise (rise_s[i]),
      .sw_fall (fall_s[i]),
      .busy    (busy_s[i])
    );
  end

  assign bus.sw_db   = db_s;
  assign bus.sw_rise = rise_s;
  assign bus.sw_fall = fall_s;
  assign bus.busy    = busy_s;

endmodule
